// File: rtl/click_event_detector_pkg.sv
// Shared definitions for the multi-channel click/long-press/repeat detector:
// FSM state encoding, default parameters and a counter-width helper.
package click_event_detector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } ch_state_e;

  localparam int DEF_N_CH            = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_LONG_CYCLES     = 1000;
  localparam int DEF_REPEAT_CYCLES   = 250;

  // Width able to hold 0..n; never narrower than one bit so n=0 stays legal.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/click_event_channel.sv
// One button channel: 2-flop synchroniser, debouncer and the
// IDLE/PRESSED/HELD classifier producing registered event pulses.
module click_event_channel
  import click_event_detector_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic pushed_i,
  output logic pressed_o,
  output logic click_o,
  output logic click_d_o,
  output logic long_press_o,
  output logic repeat_o
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int HW = cnt_width(LONG_CYCLES);
  localparam int RW = cnt_width(REPEAT_CYCLES);

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [RW-1:0] RPT_LAST  = RW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);

  logic [1:0]    sync_q;
  logic          pressed_q;
  logic [DW-1:0] db_cnt_q;

  ch_state_e     state_q;
  logic [HW-1:0] hold_q;
  logic [RW-1:0] rpt_cnt_q;
  logic          click_q;
  logic          click_d;
  logic          long_q;
  logic          rpt_q;

  // Synchroniser and debouncer: a level change is accepted only after
  // DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= 2'b00;
      pressed_q <= 1'b0;
      db_cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], pushed_i};
      if (sync_q[1] == pressed_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DB_LAST) begin
        pressed_q <= ~pressed_q;
        db_cnt_q  <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
    end
  end

  // Exported so the top can register any_click in the same cycle as click.
  assign click_d = (state_q == ST_PRESSED) && !pressed_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      hold_q    <= '0;
      rpt_cnt_q <= '0;
      click_q   <= 1'b0;
      long_q    <= 1'b0;
      rpt_q     <= 1'b0;
    end else begin
      click_q <= click_d;
      long_q  <= 1'b0;
      rpt_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pressed_q) begin
            state_q <= ST_PRESSED;
            hold_q  <= '0;
          end
        end
        ST_PRESSED: begin
          // Release is checked first so it wins over the long threshold.
          if (!pressed_q) begin
            state_q <= ST_IDLE;
          end else if (hold_q == HOLD_LAST) begin
            state_q   <= ST_HELD;
            long_q    <= 1'b1;
            rpt_cnt_q <= '0;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        ST_HELD: begin
          if (!pressed_q) begin
            state_q <= ST_IDLE;
          end else if (REPEAT_CYCLES > 0) begin
            if (rpt_cnt_q == RPT_LAST) begin
              rpt_q     <= 1'b1;
              rpt_cnt_q <= '0;
            end else begin
              rpt_cnt_q <= rpt_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pressed_o    = pressed_q;
  assign click_o      = click_q;
  assign click_d_o    = click_d;
  assign long_press_o = long_q;
  assign repeat_o     = rpt_q;

endmodule

// File: rtl/click_event_detector.sv
// N_CH independent button channels plus a registered OR of their click
// pulses, aligned with the click outputs.
module click_event_detector
  import click_event_detector_pkg::*;
#(
  parameter int N_CH            = DEF_N_CH,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] pushed,
  output logic [N_CH-1:0] pressed,
  output logic [N_CH-1:0] click,
  output logic [N_CH-1:0] long_press,
  output logic [N_CH-1:0] repeat_o,
  output logic            any_click
);

  logic [N_CH-1:0] click_d;
  logic            any_click_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    click_event_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .pushed_i    (pushed[i]),
      .pressed_o   (pressed[i]),
      .click_o     (click[i]),
      .click_d_o   (click_d[i]),
      .long_press_o(long_press[i]),
      .repeat_o    (repeat_o[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      any_click_q <= 1'b0;
    end else begin
      any_click_q <= |click_d;
    end
  end

  assign any_click = any_click_q;

endmodule

// File: tb/tb_click_event_detector.sv
// Directed bench for click_event_detector (N_CH=2, DEBOUNCE=4, LONG=20):
// one instance with REPEAT=8 and one with repeat disabled, same stimulus.
module tb_click_event_detector;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] pushed;

  logic [1:0] pressed, click, long_press, rpt;
  logic       any_click;
  logic [1:0] pressed_nr, click_nr, long_nr, rpt_nr;
  logic       any_nr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] r_press  [0:99];
  logic [1:0] r_click  [0:99];
  logic [1:0] r_long   [0:99];
  logic [1:0] r_rep    [0:99];
  logic [1:0] r_long_nr[0:99];
  logic [1:0] r_rep_nr [0:99];
  logic       r_any    [0:99];

  click_event_detector #(
    .N_CH(2), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst), .pushed(pushed), .pressed(pressed), .click(click),
    .long_press(long_press), .repeat_o(rpt), .any_click(any_click)
  );

  click_event_detector #(
    .N_CH(2), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(0)
  ) dut_nr (
    .clk(clk), .rst(rst), .pushed(pushed), .pressed(pressed_nr), .click(click_nr),
    .long_press(long_nr), .repeat_o(rpt_nr), .any_click(any_nr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive mask for hi edges then release; record outputs after edges 1..total.
  task automatic record(input logic [1:0] mask, input int hi, input int total);
    pushed = mask;
    for (int k = 1; k <= total; k++) begin
      tick(1);
      r_press[k]   = pressed;
      r_click[k]   = click;
      r_long[k]    = long_press;
      r_rep[k]     = rpt;
      r_any[k]     = any_click;
      r_long_nr[k] = long_nr;
      r_rep_nr[k]  = rpt_nr;
      if (k == hi) pushed = 2'b00;
    end
  endtask

  // sel: 0 click, 1 long, 2 repeat, 3 long (no-repeat dut), 4 repeat (no-repeat dut), 5 any_click
  function automatic int pulses(input int sel, input int ch, input int total);
    int c = 0;
    for (int k = 1; k <= total; k++) begin
      case (sel)
        0:       c += int'(r_click[k][ch]);
        1:       c += int'(r_long[k][ch]);
        2:       c += int'(r_rep[k][ch]);
        3:       c += int'(r_long_nr[k][ch]);
        4:       c += int'(r_rep_nr[k][ch]);
        default: c += int'(r_any[k]);
      endcase
    end
    return c;
  endfunction

  initial begin
    logic [4:0] acc;
    int         errs;
    logic [1:0] exp_rep;

    // Reset state
    rst    = 1'b1;
    pushed = 2'b00;
    tick(2);
    check("reset_outputs", {pressed, click, long_press, rpt, any_click}, 0);
    check("reset_outputs_nr", {pressed_nr, click_nr, long_nr, rpt_nr, any_nr}, 0);
    rst = 1'b0;
    tick(1);
    check("first_cycle_after_reset", {pressed, click, long_press, rpt, any_click}, 0);
    tick(2);

    // Short click on channel 0
    record(2'b01, 10, 25);
    check("click_pressed_edge5", r_press[5], 2'b00);
    check("click_pressed_edge6", r_press[6], 2'b01);
    check("click_release_edge15", r_press[15], 2'b01);
    check("click_release_edge16", r_press[16], 2'b00);
    check("click_edge16", r_click[16], 2'b00);
    check("click_edge17", r_click[17], 2'b01);
    check("any_click_edge17", r_any[17], 1'b1);
    check("click_count", pulses(0, 0, 25), 1);
    check("any_click_count", pulses(5, 0, 25), 1);
    check("short_no_long", pulses(1, 0, 25), 0);

    // Bounce rejection on channel 1: 2-cycle runs never reach the threshold
    acc    = '0;
    pushed = 2'b00;
    for (int k = 0; k < 30; k++) begin
      if (k % 2 == 0) pushed[1] = ~pushed[1];
      tick(1);
      acc |= {pressed[1], click[1], long_press[1], rpt[1], any_click};
    end
    pushed = 2'b00;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      acc |= {pressed[1], click[1], long_press[1], rpt[1], any_click};
    end
    check("bounce_quiet", acc, 0);

    // Glitch of DEBOUNCE-1 samples ignored, exactly DEBOUNCE samples accepted
    record(2'b10, 3, 15);
    check("glitch3_no_press", pulses(0, 1, 15) + int'(r_press[6][1]) + int'(r_press[8][1]), 0);
    record(2'b10, 4, 20);
    check("glitch4_pressed_edge6", r_press[6], 2'b10);
    check("glitch4_click_edge11", r_click[11], 2'b10);
    check("glitch4_click_count", pulses(0, 1, 20), 1);

    // Long press with repeat; release coincides with a repeat terminal count
    record(2'b01, 60, 75);
    check("long_edge26", r_long[26], 2'b00);
    check("long_edge27", r_long[27], 2'b01);
    check("long_count", pulses(1, 0, 75), 1);
    errs = 0;
    for (int k = 1; k <= 75; k++) begin
      exp_rep = (k == 35 || k == 43 || k == 51 || k == 59) ? 2'b01 : 2'b00;
      if (r_rep[k] !== exp_rep) errs++;
    end
    check("repeat_pattern_errs", errs, 0);
    check("repeat_edge35", r_rep[35], 2'b01);
    check("repeat_suppressed_edge67", r_rep[67], 2'b00);
    check("long_no_click", pulses(0, 0, 75), 0);
    check("norep_long_edge27", r_long_nr[27], 2'b01);
    check("norep_repeat_count", pulses(4, 0, 75), 0);
    tick(3);

    // Release seen exactly at hold count 19: click wins
    record(2'b01, 20, 35);
    check("boundary_click_edge27", r_click[27], 2'b01);
    check("boundary_no_long", pulses(1, 0, 35), 0);
    check("boundary_click_count", pulses(0, 0, 35), 1);

    // One cycle longer: long press, no click
    record(2'b01, 21, 40);
    check("boundary1_long_edge27", r_long[27], 2'b01);
    check("boundary1_no_click", pulses(0, 0, 40), 0);
    check("boundary1_no_repeat", pulses(2, 0, 40), 0);
    tick(3);

    // Asynchronous reset mid-press
    pushed = 2'b01;
    tick(15);
    check("pre_reset_pressed", pressed, 2'b01);
    #3;
    rst = 1'b1;
    #1;
    check("async_reset_clear", {pressed, click, long_press, rpt, any_click}, 0);
    tick(2);
    rst = 1'b0;
    record(2'b01, 10, 25);
    check("post_reset_first_cycle", {r_press[1], r_click[1], r_long[1], r_rep[1], r_any[1]}, 0);
    check("post_reset_pressed_edge5", r_press[5], 2'b00);
    check("post_reset_pressed_edge6", r_press[6], 2'b01);
    check("post_reset_click_edge17", r_click[17], 2'b01);
    check("post_reset_click_count", pulses(0, 0, 25), 1);
    check("post_reset_no_long", pulses(1, 0, 25), 0);

    // Simultaneous clicks on both channels
    record(2'b11, 10, 25);
    check("simul_click_edge17", r_click[17], 2'b11);
    check("simul_any_edge17", r_any[17], 1'b1);
    check("simul_any_edge18", r_any[18], 1'b0);
    check("simul_any_count", pulses(5, 0, 25), 1);
    check("simul_ch1_click_count", pulses(0, 1, 25), 1);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
